// File: rtl/tetris_pkg.sv
// Shared types and sizing for the TETRIS sequencer: FSM state encoding,
// board/beat geometry and counter widths.
package tetris_pkg;

    localparam int PIECES_PER_GAME = 16;
    localparam int BOARD_W         = 72;
    localparam int BEAT_W          = 8;
    localparam int NUM_BEATS       = 10;
    localparam int WAIT_TIMEOUT    = 256;

    localparam int PIECE_CNT_W = $clog2(PIECES_PER_GAME) + 1;
    localparam int BEAT_IDX_W  = $clog2(NUM_BEATS);
    localparam int WAIT_CNT_W  = $clog2(WAIT_TIMEOUT);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NUM_BEATS - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FLUSH} state_t;

    // First beat of a result: fail flag in the MSB, score in the low nibble.
    function automatic logic [BEAT_W-1:0] status_beat(input logic fail, input logic [3:0] score);
        return {fail, 3'b000, score};
    endfunction

endpackage

// File: rtl/tetris_board_ser.sv
// Captures a finished board with its score/fail status and presents it as
// NUM_BEATS byte-wide beats, one per advance.
module tetris_board_ser
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BOARD_W-1:0] board,
    input  logic [3:0]         score,
    input  logic               fail,
    input  logic               advance,
    output logic [BEAT_W-1:0]  data,
    output logic               last
);

    logic [BOARD_W-1:0]    r_board;
    logic [3:0]            r_score;
    logic                  r_fail;
    logic [BEAT_IDX_W-1:0] r_beat;
    logic [BEAT_W-1:0]     w_beats [NUM_BEATS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_board <= '0;
            r_score <= '0;
            r_fail  <= 1'b0;
            r_beat  <= '0;
        end else if (load) begin
            r_board <= board;
            r_score <= score;
            r_fail  <= fail;
            r_beat  <= '0;
        end else if (advance) begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
        end
    end

    // Beat k (k >= 1) carries board byte k-1, least significant byte first.
    assign w_beats[0] = status_beat(r_fail, r_score);
    genvar gi;
    generate
        for (gi = 1; gi < NUM_BEATS; gi++) begin : g_beat
            assign w_beats[gi] = r_board[gi*BEAT_W-1 -: BEAT_W];
        end
    endgenerate

    assign data = w_beats[r_beat];
    assign last = (r_beat == LAST_BEAT);

endmodule

// File: rtl/tetris_seq.sv
// Piece sequencer in front of a TETRIS core: issues one piece at a time,
// waits for the core's verdict and streams finished boards out as beats.
module tetris_seq
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_tetromino,
    input  logic [2:0]         cmd_position,
    input  logic               cmd_last,
    output logic               core_in_valid,
    output logic [2:0]         core_tetrominoes,
    output logic [2:0]         core_position,
    input  logic               core_score_valid,
    input  logic               core_fail,
    input  logic [3:0]         core_score,
    input  logic               core_tetris_valid,
    input  logic [BOARD_W-1:0] core_tetris,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [BEAT_W-1:0]  res_data,
    output logic               res_last,
    output logic [7:0]         games_done,
    output logic               err
);

    state_t                 r_state;
    logic [2:0]             r_tet;
    logic [2:0]             r_pos;
    logic                   r_last;
    logic                   r_fail;
    logic [PIECE_CNT_W-1:0] r_piece_cnt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [7:0]             r_games_done;
    logic                   r_err;

    logic                   w_cmd_fire;
    logic                   w_res_fire;
    logic                   w_load;
    logic [BEAT_W-1:0]      w_ser_data;
    logic                   w_ser_last;

    // Handshake outputs are decoded from the state register and forced low
    // while rst is asserted, so nothing leaks out during reset.
    assign cmd_ready        = !rst && (r_state == IDLE || r_state == FLUSH);
    assign core_in_valid    = !rst && (r_state == ISSUE);
    assign core_tetrominoes = core_in_valid ? r_tet : '0;
    assign core_position    = core_in_valid ? r_pos : '0;
    assign res_valid        = !rst && (r_state == DRAIN);
    assign res_data         = res_valid ? w_ser_data : '0;
    assign res_last         = res_valid && w_ser_last;
    assign games_done       = r_games_done;
    assign err              = r_err;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_res_fire = res_valid && res_ready;
    assign w_load     = (r_state == WAIT) && core_score_valid && core_tetris_valid;

    tetris_board_ser u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .board   (core_tetris),
        .score   (core_score),
        .fail    (core_fail),
        .advance (w_res_fire),
        .data    (w_ser_data),
        .last    (w_ser_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tet        <= '0;
            r_pos        <= '0;
            r_last       <= 1'b0;
            r_fail       <= 1'b0;
            r_piece_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_games_done <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_tet   <= cmd_tetromino;
                        r_pos   <= cmd_position;
                        r_last  <= cmd_last;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_piece_cnt <= r_piece_cnt + 1'b1;
                    r_wait_cnt  <= '0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    // A response arriving on the final counted cycle still wins.
                    if (core_score_valid) begin
                        r_fail  <= core_fail;
                        r_state <= core_tetris_valid ? DRAIN : IDLE;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_err       <= 1'b1;
                        r_piece_cnt <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_res_fire && w_ser_last) begin
                        r_games_done <= r_games_done + 8'd1;
                        r_piece_cnt  <= '0;
                        r_state      <= (r_fail && !r_last) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    if (w_cmd_fire && cmd_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_seq.sv
// Self-checking bench for tetris_seq: table vectors, directed corner cases and
// randomized games checked against a game-level reference model.
module tb_tetris_seq;
    import tetris_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid, cmd_ready, cmd_last;
    logic [2:0]         cmd_tetromino, cmd_position;
    logic               core_in_valid;
    logic [2:0]         core_tetrominoes, core_position;
    logic               core_score_valid, core_fail, core_tetris_valid;
    logic [3:0]         core_score;
    logic [BOARD_W-1:0] core_tetris;
    logic               res_valid, res_ready, res_last;
    logic [7:0]         res_data, games_done;
    logic               err;

    tetris_seq dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tetromino(cmd_tetromino),
        .cmd_position(cmd_position), .cmd_last(cmd_last),
        .core_in_valid(core_in_valid), .core_tetrominoes(core_tetrominoes),
        .core_position(core_position),
        .core_score_valid(core_score_valid), .core_fail(core_fail), .core_score(core_score),
        .core_tetris_valid(core_tetris_valid), .core_tetris(core_tetris),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .games_done(games_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 delay;
        logic               respond;
        logic [3:0]         score;
        logic               fail;
        logic               tv;
        logic [BOARD_W-1:0] board;
    } resp_t;

    typedef struct {
        logic [2:0]         tet;
        logic [2:0]         pos;
        logic [3:0]         score;
        logic               fail;
        logic               tv;
        logic [BOARD_W-1:0] board;
        int                 exp_n;
        logic [7:0]         exp_b0;
        logic [7:0]         exp_b1;
        logic [7:0]         exp_b9;
    } vec_t;

    resp_t      resp_q[$];
    logic [5:0] iss_q[$];
    logic [8:0] beat_q[$];
    logic [5:0] exp_iss[$];
    logic [8:0] exp_beats[$];
    int total = 0;
    int bad = 0;
    int gd_exp = 0;
    int rv_cycles = 0;
    int spur_cnt = 0;
    logic rr_rand = 1'b0;
    logic rr_val = 1'b1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats of one finished game, straight from the output format rules.
    task automatic push_exp_beats(input resp_t r);
        logic [BOARD_W-1:0] sh;
        for (int k = 0; k < NUM_BEATS; k++) begin
            sh = r.board >> (8 * (k - 1));
            if (k == 0) exp_beats.push_back({1'b0, r.fail, 3'b000, r.score});
            else        exp_beats.push_back({(k == NUM_BEATS - 1), sh[7:0]});
        end
    endtask

    // Core model: answers each issued piece from resp_q after its delay.
    initial begin
        resp_t r;
        int spur_seen;
        spur_seen = 0;
        core_score_valid = 0; core_fail = 0; core_score = 0;
        core_tetris_valid = 0; core_tetris = '0;
        forever begin
            @(negedge clk);
            if (spur_cnt != spur_seen) begin
                spur_seen = spur_cnt;
                @(posedge clk); #1;
                core_score_valid = 1; core_tetris_valid = 1; core_fail = 1;
                core_score = 4'hA; core_tetris = '1;
                @(posedge clk); #1;
                core_score_valid = 0; core_tetris_valid = 0; core_fail = 0;
                core_score = 0; core_tetris = '0;
            end else if (!rst && core_in_valid && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                if (r.respond) begin
                    repeat (r.delay) @(posedge clk);
                    #1;
                    core_score_valid = 1; core_score = r.score; core_fail = r.fail;
                    core_tetris_valid = r.tv; core_tetris = r.board;
                    @(posedge clk); #1;
                    core_score_valid = 0; core_tetris_valid = 0; core_fail = 0;
                    core_score = 0; core_tetris = '0;
                end
            end
        end
    end

    initial begin
        res_ready = 0;
        forever begin
            @(posedge clk); #1;
            res_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_val;
        end
    end

    // Monitor: records issues and beat handshakes, checks hold-under-backpressure.
    initial begin
        logic       prev_hold;
        logic [8:0] prev_beat;
        prev_hold = 0; prev_beat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 0;
            end else begin
                if (core_in_valid) iss_q.push_back({core_tetrominoes, core_position});
                else check("idle_core_fields_zero", {core_tetrominoes, core_position}, 6'd0);
                if (res_valid) rv_cycles++;
                if (prev_hold) begin
                    check("hold_res_valid", res_valid, 1'b1);
                    check("hold_res_beat", {res_last, res_data}, prev_beat);
                end
                if (res_valid && res_ready) beat_q.push_back({res_last, res_data});
                prev_hold = res_valid && !res_ready;
                prev_beat = {res_last, res_data};
            end
        end
    end

    task automatic send_cmd(input logic [2:0] t, input logic [2:0] p, input logic l);
        int n;
        n = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_tetromino = t; cmd_position = p; cmd_last = l;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_bound", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_tetromino = 3'($urandom_range(0, 7)); cmd_position = 0; cmd_last = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach_idle"}, cmd_ready, 1'b1);
    endtask

    task automatic clear_q();
        iss_q.delete(); beat_q.delete(); exp_iss.delete(); exp_beats.delete();
    endtask

    task automatic cmp_game(input string tag);
        check({tag, "_issue_count"}, iss_q.size(), exp_iss.size());
        check({tag, "_beat_count"}, beat_q.size(), exp_beats.size());
        for (int i = 0; i < exp_iss.size() && i < iss_q.size(); i++)
            check({tag, "_issue"}, iss_q[i], exp_iss[i]);
        for (int i = 0; i < exp_beats.size() && i < beat_q.size(); i++)
            check({tag, "_beat"}, beat_q[i], exp_beats[i]);
        check({tag, "_games_done"}, games_done, 8'(gd_exp));
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        vec_t  vecs[5];
        resp_t r;
        logic [7:0] b30[10];
        int n;
        logic flush;
        logic [95:0] rnd;
        logic [2:0] gt[$];
        logic [2:0] gp[$];

        cmd_valid = 0; cmd_tetromino = 0; cmd_position = 0; cmd_last = 0;
        rst = 1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_core_in_valid", core_in_valid, 1'b0);
        check("rst_core_fields", {core_tetrominoes, core_position}, 6'd0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data_last", {res_last, res_data}, 9'd0);
        check("rst_games_done", games_done, 8'd0);
        check("rst_err", err, 1'b0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // ---------------- 16-piece game, last piece completes a board ----------------
        b30 = '{8'h04, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        for (int i = 0; i < 15; i++) resp_q.push_back('{2, 1'b1, 4'(i), 1'b0, 1'b0, '0});
        resp_q.push_back('{3, 1'b1, 4'h4, 1'b0, 1'b1, 72'h0123456789ABCDEF01});
        for (int i = 0; i < 16; i++) send_cmd(3'(i), 3'(i + 1), (i == 15));
        wait_idle("game16");
        check("game16_issue_count", iss_q.size(), 16);
        check("game16_beat_count", beat_q.size(), 10);
        for (int k = 0; k < 10; k++) check("game16_beat", beat_q[k], {(k == 9), b30[k]});
        check("game16_games_done", games_done, 8'd1);
        gd_exp = 1;
        $display("game16: issues=%0d beats=%0d games_done=%0d", iss_q.size(), beat_q.size(), games_done);
        clear_q();

        // ---------------- table-driven single-piece games ----------------
        vecs[0] = '{3'd3, 3'd2, 4'h4, 1'b0, 1'b1, 72'h0123456789ABCDEF01, 10, 8'h04, 8'h01, 8'h01};
        vecs[1] = '{3'd5, 3'd7, 4'hF, 1'b1, 1'b1, 72'hA5000000000000005A, 10, 8'h8F, 8'h5A, 8'hA5};
        vecs[2] = '{3'd0, 3'd0, 4'h0, 1'b1, 1'b1, 72'hFF0000000000000000, 10, 8'h80, 8'h00, 8'hFF};
        vecs[3] = '{3'd7, 3'd1, 4'h9, 1'b0, 1'b0, 72'h000000000000000123, 0,  8'h00, 8'h00, 8'h00};
        vecs[4] = '{3'd1, 3'd6, 4'h0, 1'b0, 1'b1, 72'h00FFFFFFFFFFFFFFFF, 10, 8'h00, 8'hFF, 8'h00};
        for (int v = 0; v < 5; v++) begin
            resp_q.push_back('{3, 1'b1, vecs[v].score, vecs[v].fail, vecs[v].tv, vecs[v].board});
            send_cmd(vecs[v].tet, vecs[v].pos, 1'b1);
            @(negedge clk);
            check("vec_issue_latency", core_in_valid, 1'b1);
            check("vec_issue_fields", {core_tetrominoes, core_position}, {vecs[v].tet, vecs[v].pos});
            wait_idle("vec");
            check("vec_beat_count", beat_q.size(), vecs[v].exp_n);
            if (vecs[v].exp_n == 10) begin
                check("vec_beat0", beat_q[0], {1'b0, vecs[v].exp_b0});
                check("vec_beat1", beat_q[1], {1'b0, vecs[v].exp_b1});
                check("vec_beat9", beat_q[9], {1'b1, vecs[v].exp_b9});
                gd_exp++;
            end
            check("vec_games_done", games_done, 8'(gd_exp));
            $display("vec %0d: tet=%0d pos=%0d beats=%0d games_done=%0d",
                     v, vecs[v].tet, vecs[v].pos, beat_q.size(), games_done);
            clear_q();
        end

        // ---------------- one piece, score only; stray core responses in IDLE ----------------
        n = rv_cycles;
        resp_q.push_back('{5, 1'b1, 4'h0, 1'b0, 1'b0, '0});
        send_cmd(3'd3, 3'd2, 1'b0);
        wait_idle("single");
        check("single_issue_count", iss_q.size(), 1);
        check("single_issue", iss_q[0], {3'd3, 3'd2});
        check("single_res_valid_cycles", rv_cycles, n);
        spur_cnt++;
        repeat (5) @(negedge clk);
        check("stray_res_valid_cycles", rv_cycles, n);
        check("stray_cmd_ready", cmd_ready, 1'b1);
        $display("single: issues=%0d res_valid_cycles=%0d", iss_q.size(), rv_cycles - n);
        clear_q();

        // ---------------- fail on piece 3 -> flush rest of game ----------------
        resp_q.push_back('{2, 1'b1, 4'h1, 1'b0, 1'b0, '0});
        resp_q.push_back('{2, 1'b1, 4'h2, 1'b0, 1'b0, '0});
        r = '{2, 1'b1, 4'h5, 1'b1, 1'b1, 72'h13579BDF02468ACE11};
        resp_q.push_back(r);
        for (int i = 0; i < 3; i++) exp_iss.push_back({3'(i), 3'(7 - i)});
        push_exp_beats(r);
        gd_exp++;
        for (int i = 0; i < 16; i++) send_cmd(3'(i), 3'(7 - i), (i == 15));
        wait_idle("flush");
        check("flush_beat0", beat_q[0], 9'h085);
        cmp_game("flush");
        $display("flush: issues=%0d beats=%0d", iss_q.size(), beat_q.size());
        clear_q();
        resp_q.push_back('{2, 1'b1, 4'h0, 1'b0, 1'b0, '0});
        send_cmd(3'd6, 3'd6, 1'b1);
        @(negedge clk);
        check("after_flush_issue", core_in_valid, 1'b1);
        wait_idle("after_flush");
        clear_q();

        // ---------------- backpressure at beat 2 ----------------
        r = '{2, 1'b1, 4'h7, 1'b0, 1'b1, 72'h112233445566778899};
        resp_q.push_back(r);
        push_exp_beats(r);
        exp_iss.push_back({3'd2, 3'd4});
        gd_exp++;
        @(posedge clk); rr_val = 0;
        send_cmd(3'd2, 3'd4, 1'b1);
        n = 0;
        while (!res_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("bp_res_valid_seen", res_valid, 1'b1);
        @(posedge clk); rr_val = 1;
        @(posedge clk);
        @(posedge clk); rr_val = 0;
        repeat (7) begin
            @(negedge clk);
            check("bp_hold_beat2", {res_valid, res_last, res_data}, {2'b10, 8'h88});
        end
        @(posedge clk); rr_val = 1;
        wait_idle("bp");
        cmp_game("bp");
        $display("backpressure: beats=%0d", beat_q.size());
        clear_q();

        // ---------------- randomized games against the reference model ----------------
        for (int g = 0; g < 6; g++) begin
            n = $urandom_range(1, 16);
            flush = 0;
            gt.delete(); gp.delete();
            for (int i = 0; i < n; i++) begin
                gt.push_back(3'($urandom_range(0, 7)));
                gp.push_back(3'($urandom_range(0, 7)));
                if (flush) begin
                    if (i == n - 1) flush = 0;
                end else begin
                    rnd = {$urandom, $urandom, $urandom};
                    r = '{$urandom_range(1, 6), 1'b1, 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), rnd[71:0]};
                    resp_q.push_back(r);
                    exp_iss.push_back({gt[i], gp[i]});
                    if (r.tv) begin
                        push_exp_beats(r);
                        gd_exp++;
                        if (r.fail && i != n - 1) flush = 1;
                    end
                end
            end
            rr_rand = 1;
            for (int i = 0; i < n; i++) send_cmd(gt[i], gp[i], (i == n - 1));
            wait_idle("rand");
            rr_rand = 0;
            cmp_game("rand");
            $display("rand game %0d: cmds=%0d issues=%0d beats=%0d games_done=%0d",
                     g, n, iss_q.size(), beat_q.size(), games_done);
            clear_q();
        end

        // ---------------- reset in the middle of DRAIN ----------------
        @(posedge clk); rr_val = 1;
        resp_q.push_back('{2, 1'b1, 4'h3, 1'b0, 1'b1, 72'hCAFEBABE0011223344});
        send_cmd(3'd1, 3'd1, 1'b1);
        n = 0;
        while (beat_q.size() < 4 && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        check("mid_drain_reached_beat4", beat_q.size(), 4);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        gd_exp = 0;
        n = rv_cycles;
        @(negedge clk);
        check("mid_drain_res_valid", res_valid, 1'b0);
        check("mid_drain_games_done", games_done, 8'd0);
        repeat (5) @(negedge clk);
        check("mid_drain_no_more_beats", beat_q.size(), 4);
        check("mid_drain_res_valid_cycles", rv_cycles, n);
        $display("mid-drain reset: beats=%0d games_done=%0d", beat_q.size(), games_done);
        clear_q();
        resp_q.delete();

        // ---------------- core timeout ----------------
        resp_q.push_back('{0, 1'b0, 4'h0, 1'b0, 1'b0, '0});
        send_cmd(3'd4, 3'd3, 1'b0);
        @(negedge clk);
        check("to_issue", core_in_valid, 1'b1);
        repeat (256) @(negedge clk);
        check("to_err_before", err, 1'b0);
        @(negedge clk);
        check("to_err_set", err, 1'b1);
        check("to_idle_ready", cmd_ready, 1'b1);
        resp_q.push_back('{2, 1'b1, 4'h1, 1'b0, 1'b0, '0});
        send_cmd(3'd2, 3'd2, 1'b1);
        @(negedge clk);
        check("to_next_issue", core_in_valid, 1'b1);
        wait_idle("to_next");
        check("to_err_sticky", err, 1'b1);
        rst = 1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("to_err_cleared", err, 1'b0);
        $display("timeout: err cleared by reset=%0d", !err);
        clear_q();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tetris_seq.md
TETRIS_SEQ -- requirements
Module: tetris_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_tetromino in 3, cmd_position in 3, cmd_last in 1 (last piece of game): piece command stream.
REQ-004 SHALL have ports: core_in_valid out 1, core_tetrominoes out 3, core_position out 3: drive to TETRIS core.
REQ-005 SHALL have ports: core_score_valid in 1, core_fail in 1, core_score in 4, core_tetris_valid in 1, core_tetris in 72: results from TETRIS core.
REQ-006 SHALL have ports: res_valid out 1, res_ready in 1, res_data out 8, res_last out 1: per-game result stream.
REQ-007 SHALL have ports: games_done out 8 (wrapping count of games drained), err out 1 (sticky core timeout).

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN, FLUSH.
REQ-009 SHALL assert cmd_ready only in IDLE and FLUSH.
REQ-010 IDLE: on cmd_valid&cmd_ready, SHALL latch tetromino/position/last and go to ISSUE.
REQ-011 ISSUE: SHALL assert core_in_valid for exactly one cycle with the latched fields, increment piece_cnt (5 bits), then go to WAIT; core_tetrominoes/core_position SHALL be 0 whenever core_in_valid is 0.
REQ-012 WAIT: on core_score_valid, SHALL capture core_score and core_fail; if core_tetris_valid is high in the same cycle, SHALL also capture core_tetris and go to DRAIN, else go to IDLE.
REQ-013 WAIT: SHALL count cycles; at 256 cycles without core_score_valid, SHALL set err, clear piece_cnt, and go to IDLE.
REQ-014 DRAIN: SHALL emit 10 beats: beat 0 = {fail, 3'b000, score}; beat k (1..9) = core_tetris[8k-1:8k-8]; res_last high on beat 9 only.
REQ-015 DRAIN: res_data/res_last SHALL hold stable while res_valid&!res_ready; a beat advances only on res_valid&res_ready.
REQ-016 SHALL increment games_done (mod 256) and clear piece_cnt on the beat-9 handshake.
REQ-017 After DRAIN: if captured fail=1 and latched last=0, SHALL go to FLUSH, else to IDLE.
REQ-018 FLUSH: SHALL accept and discard commands with no core_in_valid, and return to IDLE on acceptance of a command with cmd_last=1.
REQ-019 SHALL ignore core_score_valid/core_tetris_valid outside WAIT.
REQ-020 The issue latency SHALL be fixed: core_in_valid asserts in the cycle after command acceptance.
REQ-021 res_valid SHALL be high in DRAIN only; at most one core command SHALL be outstanding at any time.
REQ-022 err SHALL be cleared only by rst.

Reset
REQ-023 With rst high at a clock edge: state=IDLE; piece_cnt=0; beat index=0; games_done=0; err=0; all captured data=0.
REQ-024 During reset, cmd_ready, core_in_valid, res_valid, res_last, res_data, core_tetrominoes and core_position SHALL be 0.
REQ-025 Reset asserted mid-WAIT or mid-DRAIN SHALL abandon the game without emitting further beats.

Structure
REQ-026 Package tetris_pkg SHALL hold: the state enum, PIECES_PER_GAME=16, BOARD_W=72, BEAT_W=8, NUM_BEATS=10, WAIT_TIMEOUT=256.
REQ-027 Board capture and beat selection SHALL be a sub-module tetris_board_ser with inputs load, board[71:0], score, fail, and advance, and outputs data[7:0] and last.
REQ-028 tetris_seq SHALL hold the FSM, counters, and the command latch.

Verification
REQ-029 Scenario: 1 cmd (tet=3, pos=2, last=0); core returns score_valid with score=0 and fail=0 after 5 cycles, with no tetris_valid -> one core_in_valid pulse carrying 3/2, back to IDLE, res_valid stays 0.
REQ-030 Scenario: 16 cmds; the 16th response has tetris_valid=1, score=4, fail=0, board=72'h0123456789ABCDEF01 -> beats in order 04, 01, EF, CD, AB, 89, 67, 45, 23, 01; res_last on the 10th beat; games_done=1.
REQ-031 Scenario: cmd 3 of a game gets fail=1 with tetris_valid=1 -> beat 0 = 0x8s (s = score); FLUSH then swallows cmds 4..16 with no core_in_valid; IDLE follows after the cmd_last handshake.
REQ-032 Scenario: res_ready held low for 7 cycles at beat 2 -> res_data is constant at beat 2's value; no beat is skipped or duplicated.
REQ-033 Scenario: no core_score_valid for 256 cycles after issue -> err=1, state=IDLE, and the next cmd is accepted; a later rst clears err.
REQ-034 Scenario: rst pulsed mid-DRAIN at beat 4 -> res_valid=0 and games_done=0 on the next cycle.
